// File: rtl/slow_pulse_scheduler.sv
// -----------------------------------------------------------------------------
// slow_pulse_scheduler
//
// Slow-domain front end of the slow-to-fast pulse synchronizer. Bursty
// single-cycle event requests are accumulated in a pending counter. They are
// re-issued as clean one-cycle pulses, each followed by at least GAP_CYCLES
// low cycles, so the fast-domain edge detector sees every event exactly once.
//
// State table:
//   state | meaning
//   IDLE  | no pulse in flight; issue allowed
//   PULSE | o_pulse high for exactly one cycle
//   GAP   | enforced low time after a pulse; issue allowed on its last cycle
//
// Parameters:
//   CNT_W       width of the pending-event counter (saturates at 2**CNT_W-1)
//   GAP_CYCLES  minimum low cycles after each pulse, must be >= 1
//
// Ports:
//   i_slow_clk  slow-domain clock
//   i_rst_n     asynchronous active-low reset
//   i_clr       synchronous clear of pending events, overflow and FSM
//   i_event     event request, one event per high cycle
//   o_pulse     registered issued pulse, one i_slow_clk cycle wide
//   o_pending   accepted events not yet issued
//   o_overflow  sticky flag: an event was dropped because the counter was full
//   o_busy      FSM not idle or events still pending
// -----------------------------------------------------------------------------
module slow_pulse_scheduler #(
  parameter int CNT_W      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic             i_slow_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_event,
  output logic             o_pulse,
  output logic [CNT_W-1:0] o_pending,
  output logic             o_overflow,
  output logic             o_busy
);

  generate
    if (GAP_CYCLES < 1) begin : g_bad_gap
      $error("slow_pulse_scheduler: GAP_CYCLES must be >= 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt
      $error("slow_pulse_scheduler: CNT_W must be >= 1");
    end
  endgenerate

  // The gap counter only ever holds GAP_CYCLES-1 down to 0.
  localparam int              GW        = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0]   GAP_LOAD  = GW'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [GW-1:0]    gap_cnt;
  logic [GW-1:0]    gap_cnt_nxt;
  logic             pulse_nxt;
  logic             last_gap;
  logic             issue;
  logic             accept;
  logic             inc;
  logic             drop;
  logic [CNT_W-1:0] pend_nxt;

  assign last_gap = (state == ST_GAP) && (gap_cnt == '0);

  // A new pulse may start from IDLE or on the final GAP cycle; an event
  // arriving this very cycle counts as work even with nothing pending.
  assign issue = ((state == ST_IDLE) || last_gap) &&
                 ((o_pending != '0) || i_event) && !i_clr;

  // A full counter still accepts an event when one is issued in the same
  // cycle, because the count stays at its maximum.
  assign accept = (o_pending != PEND_MAX) || issue;
  assign inc    = i_event && accept && !i_clr;
  assign drop   = i_event && !accept && !i_clr;

  // State register
  always_ff @(posedge i_slow_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      gap_cnt <= '0;
      o_pulse <= 1'b0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_cnt_nxt;
      o_pulse <= pulse_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (i_clr) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (issue) state_nxt = ST_PULSE;
        ST_PULSE: state_nxt = ST_GAP;
        ST_GAP: begin
          if (last_gap) state_nxt = issue ? ST_PULSE : ST_IDLE;
        end
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs and gap timer: the pulse flop follows entry into PULSE, and the
  // gap down-counter is loaded on the PULSE->GAP transition.
  always_comb begin
    pulse_nxt   = (state_nxt == ST_PULSE);
    gap_cnt_nxt = gap_cnt;
    if (i_clr) begin
      gap_cnt_nxt = '0;
    end else if ((state == ST_PULSE) && (state_nxt == ST_GAP)) begin
      gap_cnt_nxt = GAP_LOAD;
    end else if ((state == ST_GAP) && (gap_cnt != '0)) begin
      gap_cnt_nxt = gap_cnt - GW'(1);
    end
  end

  // Pending counter: simultaneous accept and issue leave it unchanged.
  always_comb begin
    pend_nxt = o_pending;
    if (inc && !issue) begin
      pend_nxt = o_pending + CNT_W'(1);
    end else if (issue && !inc) begin
      pend_nxt = o_pending - CNT_W'(1);
    end
  end

  always_ff @(posedge i_slow_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pending  <= '0;
      o_overflow <= 1'b0;
    end else if (i_clr) begin
      o_pending  <= '0;
      o_overflow <= 1'b0;
    end else begin
      o_pending <= pend_nxt;
      if (drop) o_overflow <= 1'b1;
    end
  end

  assign o_busy = (state != ST_IDLE) || (o_pending != '0);

endmodule

// File: tb/tb_slow_pulse_scheduler.sv
// -----------------------------------------------------------------------------
// Bench for slow_pulse_scheduler. Two instances share the stimulus:
//   dut_a  CNT_W=4, GAP_CYCLES=1
//   dut_b  CNT_W=2, GAP_CYCLES=3
// A per-instance event model (pending count, remaining busy cycles) predicts
// every output each cycle; directed scenarios add hand-computed expectations.
// Inputs change 1 time unit after the rising edge, outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_slow_pulse_scheduler;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr   = 1'b0;
  logic       ev    = 1'b0;

  logic       pulse_a, ovf_a, busy_a;
  logic [3:0] pend_a;
  logic       pulse_b, ovf_b, busy_b;
  logic [1:0] pend_b;

  always #5 clk = ~clk;

  slow_pulse_scheduler #(.CNT_W(4), .GAP_CYCLES(1)) dut_a (
    .i_slow_clk (clk),
    .i_rst_n    (rst_n),
    .i_clr      (clr),
    .i_event    (ev),
    .o_pulse    (pulse_a),
    .o_pending  (pend_a),
    .o_overflow (ovf_a),
    .o_busy     (busy_a)
  );

  slow_pulse_scheduler #(.CNT_W(2), .GAP_CYCLES(3)) dut_b (
    .i_slow_clk (clk),
    .i_rst_n    (rst_n),
    .i_clr      (clr),
    .i_event    (ev),
    .o_pulse    (pulse_b),
    .o_pending  (pend_b),
    .o_overflow (ovf_b),
    .o_busy     (busy_b)
  );

  // Model: rem = cycles the scheduler is still non-idle (pulse cycle plus gap
  // cycles); a new pulse may be scheduled when rem <= 1.
  int m_pend [2];
  int m_rem  [2];
  bit m_ovf  [2];
  bit m_pulse[2];
  int n_pend [2];
  int n_rem  [2];
  bit n_ovf  [2];
  bit n_pulse[2];

  function automatic int mmax(input int i);
    return (i == 0) ? 15 : 3;
  endfunction

  function automatic int mgap(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      n_pend[i]  = m_pend[i];
      n_rem[i]   = m_rem[i];
      n_ovf[i]   = m_ovf[i];
      n_pulse[i] = 1'b0;
      if (clr) begin
        n_pend[i] = 0;
        n_rem[i]  = 0;
        n_ovf[i]  = 1'b0;
      end else begin
        n_pulse[i] = (m_rem[i] <= 1) && ((m_pend[i] > 0) || ev);
        n_pend[i]  = m_pend[i]
                   + ((ev && ((m_pend[i] < mmax(i)) || n_pulse[i])) ? 1 : 0)
                   - (n_pulse[i] ? 1 : 0);
        if (ev && !((m_pend[i] < mmax(i)) || n_pulse[i])) n_ovf[i] = 1'b1;
        n_rem[i] = n_pulse[i] ? mgap(i) + 1 : ((m_rem[i] > 0) ? m_rem[i] - 1 : 0);
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_pend[i]  <= 0;
        m_rem[i]   <= 0;
        m_ovf[i]   <= 1'b0;
        m_pulse[i] <= 1'b0;
      end
    end else begin
      m_pend  <= n_pend;
      m_rem   <= n_rem;
      m_ovf   <= n_ovf;
      m_pulse <= n_pulse;
    end
  end

  int total = 0;
  int bad   = 0;
  int npa   = 0;
  int npb   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // One slow cycle: drive inputs after the edge, sample mid-cycle and compare
  // both instances against the model.
  task automatic tick(input bit e, input bit c);
    @(posedge clk);
    #1;
    ev  = e;
    clr = c;
    @(negedge clk);
    chk("a_pulse",   int'(pulse_a), int'(m_pulse[0]));
    chk("a_pending", int'(pend_a),  m_pend[0]);
    chk("a_ovf",     int'(ovf_a),   int'(m_ovf[0]));
    chk("a_busy",    int'(busy_a),  int'((m_rem[0] > 0) || (m_pend[0] > 0)));
    chk("b_pulse",   int'(pulse_b), int'(m_pulse[1]));
    chk("b_pending", int'(pend_b),  m_pend[1]);
    chk("b_ovf",     int'(ovf_b),   int'(m_ovf[1]));
    chk("b_busy",    int'(busy_b),  int'((m_rem[1] > 0) || (m_pend[1] > 0)));
    if (pulse_a) npa++;
    if (pulse_b) npb++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 1'b0);
  endtask

  int pa0, pb0;

  initial begin
    // Reset state
    #3;
    chk("rst_pulse_a", int'(pulse_a), 0);
    chk("rst_pend_a",  int'(pend_a),  0);
    chk("rst_ovf_a",   int'(ovf_a),   0);
    chk("rst_busy_a",  int'(busy_a),  0);
    chk("rst_pulse_b", int'(pulse_b), 0);
    chk("rst_busy_b",  int'(busy_b),  0);
    @(negedge clk);
    rst_n = 1'b1;
    pa0 = npa; pb0 = npb;
    idle(10);
    chk("idle_pulses_a", npa - pa0, 0);
    chk("idle_pulses_b", npb - pb0, 0);

    // Single event at c0
    tick(1'b1, 1'b0);
    chk("t2_c0_pulse", int'(pulse_a), 0);
    tick(1'b0, 1'b0);
    chk("t2_c1_pulse", int'(pulse_a), 1);
    chk("t2_c1_pend",  int'(pend_a),  0);
    chk("t2_c1_busy",  int'(busy_a),  1);
    tick(1'b0, 1'b0);
    chk("t2_c2_pulse", int'(pulse_a), 0);
    chk("t2_c2_busy",  int'(busy_a),  1);
    tick(1'b0, 1'b0);
    chk("t2_c3_busy",  int'(busy_a),  0);
    idle(6);

    // Event high c0-c2: pulses at c1, c3, c5
    pa0 = npa;
    for (int c = 0; c <= 8; c++) begin
      tick(c <= 2, 1'b0);
      chk("t3_pulse_a", int'(pulse_a), int'(c == 1 || c == 3 || c == 5));
      chk("t3_pend_a",  int'(pend_a),  (c >= 2 && c <= 4) ? 1 : 0);
    end
    chk("t3_count_a", npa - pa0, 3);
    idle(20);

    // Saturation on the narrow instance: event high c0-c7
    pb0 = npb;
    for (int c = 0; c <= 20; c++) begin
      tick(c <= 7, 1'b0);
      chk("t4_pulse_b", int'(pulse_b),
          int'(c == 1 || c == 5 || c == 9 || c == 13 || c == 17));
      if (c == 4) chk("t4_c4_pend_b", int'(pend_b), 3);
      if (c == 5) chk("t4_c5_ovf_b",  int'(ovf_b),  0);
      if (c == 6) chk("t4_c6_ovf_b",  int'(ovf_b),  1);
    end
    chk("t4_count_b", npb - pb0, 5);
    chk("t4_ovf_sticky_b", int'(ovf_b), 1);
    idle(4);

    // Clear during GAP with pending=2, together with an event
    for (int c = 0; c <= 3; c++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    chk("t5_c4_pend_a",  int'(pend_a),  2);
    chk("t5_c4_busy_a",  int'(busy_a),  1);
    chk("t5_c4_pulse_a", int'(pulse_a), 0);
    pa0 = npa; pb0 = npb;
    tick(1'b0, 1'b0);
    chk("t5_c5_pend_a", int'(pend_a), 0);
    chk("t5_c5_ovf_a",  int'(ovf_a),  0);
    chk("t5_c5_busy_a", int'(busy_a), 0);
    chk("t5_c5_ovf_b",  int'(ovf_b),  0);
    chk("t5_c5_pend_b", int'(pend_b), 0);
    idle(9);
    chk("t5_after_a", npa - pa0, 0);
    chk("t5_after_b", npb - pb0, 0);

    // Asynchronous reset in the middle of a pulse
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    chk("t6_pulse_before", int'(pulse_a), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_pulse_a", int'(pulse_a), 0);
    chk("t6_async_pulse_b", int'(pulse_b), 0);
    chk("t6_async_busy_a",  int'(busy_a),  0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pa0 = npa; pb0 = npb;
    idle(10);
    chk("t6_after_a", npa - pa0, 0);
    chk("t6_after_b", npb - pb0, 0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    chk("t6_new_event", int'(pulse_a), 1);
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
